// File: rtl/io_mem_port.sv
// IO-side initiator for the shared instruction/data memory: streams host bytes
// into consecutive words (LOAD) and streams consecutive words out as bytes (DUMP).
module io_mem_port #(
   parameter int MEM_SIZE = 200,
   parameter int ADDR_W   = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_DUMP,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [ADDR_W-1:0] CMD_LEN,
   input  logic              RX_VALID,
   output logic              RX_READY,
   input  logic [7:0]        RX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY,
   output logic [7:0]        TX_DATA,
   output logic [15:0]       RADDR_IO,
   input  logic [15:0]       DATA_OUT_IO,
   output logic [15:0]       WADDR_IO,
   output logic [15:0]       DATA_IN_IO,
   output logic              MW_IO_ON,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [3:0]        DBG_STATE
);

   // Every channel (CMD, RX, TX) transfers exactly on a posedge where valid && ready;
   // a raised TX_VALID keeps TX_VALID/TX_DATA stable until that transfer happens.
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ERR   = 4'd1,
      S_FIN   = 4'd2,
      S_LD_HI = 4'd3,
      S_LD_LO = 4'd4,
      S_LD_WR = 4'd5,
      S_DP_RD = 4'd6,
      S_DP_HI = 4'd7,
      S_DP_LO = 4'd8
   } state_t;

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       word_q, word_d;
   logic [15:0]       waddr_q, waddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       raddr_q, raddr_d;
   logic              mw_q, mw_d;
   logic [ADDR_W:0]   cmd_end;

   assign cmd_end    = {1'b0, CMD_ADDR} + {1'b0, CMD_LEN};
   assign RADDR_IO   = raddr_q;
   assign WADDR_IO   = waddr_q;
   assign DATA_IN_IO = wdata_q;
   assign MW_IO_ON   = mw_q;
   assign BUSY       = (state_q != S_IDLE);
   assign DONE       = (state_q == S_FIN);
   assign ERR        = (state_q == S_ERR);
   assign DBG_STATE  = state_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      word_d    = word_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      raddr_d   = raddr_q;
      mw_d      = 1'b0;
      CMD_READY = 1'b0;
      RX_READY  = 1'b0;
      TX_VALID  = 1'b0;
      TX_DATA   = 8'h00;
      case (state_q)
         S_IDLE: begin
            CMD_READY = 1'b1;
            if (CMD_VALID) begin
               addr_d = CMD_ADDR;
               cnt_d  = CMD_LEN;
               // 17-bit sum so a huge length cannot wrap back into range
               if (cmd_end > MEM_LIMIT) begin
                  state_d = S_ERR;
               end else if (CMD_LEN == '0) begin
                  state_d = S_FIN;
               end else if (CMD_DUMP) begin
                  raddr_d = 16'(CMD_ADDR);
                  state_d = S_DP_RD;
               end else begin
                  state_d = S_LD_HI;
               end
            end
         end
         S_ERR: state_d = S_IDLE;
         S_FIN: state_d = S_IDLE;
         S_LD_HI: begin
            RX_READY = 1'b1;
            if (RX_VALID) begin
               hi_d    = RX_DATA;
               state_d = S_LD_LO;
            end
         end
         S_LD_LO: begin
            RX_READY = 1'b1;
            if (RX_VALID) begin
               waddr_d = 16'(addr_q);
               wdata_d = {hi_q, RX_DATA};
               mw_d    = 1'b1;
               state_d = S_LD_WR;
            end
         end
         S_LD_WR: begin
            // memory commits on this cycle's negedge; the strobe drops next edge
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == ADDR_W'(1)) ? S_FIN : S_LD_HI;
         end
         S_DP_RD: begin
            word_d  = DATA_OUT_IO;
            state_d = S_DP_HI;
         end
         S_DP_HI: begin
            TX_VALID = 1'b1;
            TX_DATA  = word_q[15:8];
            if (TX_READY) state_d = S_DP_LO;
         end
         S_DP_LO: begin
            TX_VALID = 1'b1;
            TX_DATA  = word_q[7:0];
            if (TX_READY) begin
               addr_d  = addr_q + 1'b1;
               raddr_d = 16'(addr_q + 1'b1);
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == ADDR_W'(1)) ? S_FIN : S_DP_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         word_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         raddr_q <= '0;
         mw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         word_q  <= word_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         mw_q    <= mw_d;
      end
   end

endmodule

// File: tb/tb_io_mem_port.sv
// Directed bench for io_mem_port with a 200-word memory model on the IO port,
// byte/write scoreboards fed from the stimulus and drained at the DUT outputs.
module tb_io_mem_port;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        CMD_DUMP;
   logic [15:0] CMD_ADDR;
   logic [15:0] CMD_LEN;
   logic        RX_VALID;
   logic        RX_READY;
   logic [7:0]  RX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic [7:0]  TX_DATA;
   logic [15:0] RADDR_IO;
   logic [15:0] DATA_OUT_IO;
   logic [15:0] WADDR_IO;
   logic [15:0] DATA_IN_IO;
   logic        MW_IO_ON;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [3:0]  DBG_STATE;

   io_mem_port #(.MEM_SIZE(200), .ADDR_W(16)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DUMP(CMD_DUMP),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
      .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_DATA(RX_DATA),
      .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
      .RADDR_IO(RADDR_IO), .DATA_OUT_IO(DATA_OUT_IO),
      .WADDR_IO(WADDR_IO), .DATA_IN_IO(DATA_IN_IO), .MW_IO_ON(MW_IO_ON),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp_q[$];
   logic [31:0] exp_wr_q[$];

   logic [15:0] mem [0:199];
   logic        mem_init_done = 1'b0;
   int          mw_cycles, mw_pulses, done_cnt, err_cnt, tx_cnt;
   logic        mw_prev = 1'b0;
   logic        tx_prev_valid = 1'b0;
   logic        tx_prev_acc = 1'b0;
   logic [7:0]  tx_prev_data = 8'h00;

   assign DATA_OUT_IO = (RADDR_IO < 16'd200) ? mem[RADDR_IO[7:0]] : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // memory model: initial contents, then IO writes commit on the negedge
   always @(negedge CLK) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 200; i++) mem[i] = 16'hF000 | 16'(i);
         mem[0] = 16'hC011;
         mem[1] = 16'hC122;
         mem[2] = 16'hC244;
         mem_init_done = 1'b1;
      end else if (MW_IO_ON && WADDR_IO < 16'd200) begin
         mem[WADDR_IO[7:0]] = DATA_IN_IO;
      end
   end

   // output monitor / scoreboard drain
   always @(negedge CLK) begin
      logic [7:0]  eb;
      logic [31:0] ew;
      if (MW_IO_ON) begin
         mw_cycles++;
         if (!mw_prev) mw_pulses++;
         ew = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 32'hxxxxxxxx;
         chk("mem_write", {WADDR_IO, DATA_IN_IO}, ew);
      end
      mw_prev = MW_IO_ON;
      if (DONE) done_cnt++;
      if (ERR) err_cnt++;
      if (tx_prev_valid && !tx_prev_acc)
         chk("tx_hold", {23'h0, TX_VALID, TX_DATA}, {23'h0, 1'b1, tx_prev_data});
      if (TX_VALID && TX_READY) begin
         tx_cnt++;
         eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk("tx_byte", {24'h0, TX_DATA}, {24'h0, eb});
      end
      tx_prev_valid = TX_VALID;
      tx_prev_acc   = TX_VALID && TX_READY;
      tx_prev_data  = TX_DATA;
   end

   // driver tasks
   task automatic clr_mon();
      mw_cycles = 0;
      mw_pulses = 0;
      done_cnt  = 0;
      err_cnt   = 0;
      tx_cnt    = 0;
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_cmd(input logic dump, input logic [15:0] addr, input logic [15:0] len,
                           input logic keep_valid);
      int n = 0;
      CMD_DUMP  = dump;
      CMD_ADDR  = addr;
      CMD_LEN   = len;
      CMD_VALID = 1'b1;
      while (!CMD_READY && n < 50) begin
         cycle();
         n++;
      end
      chk("cmd_accept_in_time", {31'h0, n < 50}, 32'h1);
      cycle();
      if (!keep_valid) CMD_VALID = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      RX_DATA  = b;
      RX_VALID = 1'b1;
      while (!RX_READY && n < 50) begin
         cycle();
         n++;
      end
      chk("rx_accept_in_time", {31'h0, n < 50}, 32'h1);
      cycle();
      RX_VALID = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] addr, input logic [15:0] w, input logic expect_wr);
      if (expect_wr) exp_wr_q.push_back({addr, w});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!DONE && n < 200) begin
         cycle();
         n++;
      end
      chk(tag, {31'h0, DONE}, 32'h1);
   endtask

   initial begin
      RST = 1'b1;
      CMD_VALID = 1'b0;
      CMD_DUMP = 1'b0;
      CMD_ADDR = 16'h0;
      CMD_LEN = 16'h0;
      RX_VALID = 1'b0;
      RX_DATA = 8'h00;
      TX_READY = 1'b0;
      clr_mon();
      repeat (3) cycle();
      chk("rst_busy", {31'h0, BUSY}, 32'h0);
      chk("rst_mw", {31'h0, MW_IO_ON}, 32'h0);
      chk("rst_waddr", {16'h0, WADDR_IO}, 32'h0);
      chk("rst_wdata", {16'h0, DATA_IN_IO}, 32'h0);
      chk("rst_raddr", {16'h0, RADDR_IO}, 32'h0);
      RST = 1'b0;
      cycle();
      chk("idle_ready", {31'h0, CMD_READY}, 32'h1);
      chk("idle_outs", {27'h0, BUSY, DONE, ERR, TX_VALID, RX_READY}, 32'h0);
      chk("idle_state", {28'h0, DBG_STATE}, 32'h0);

      // 1: LOAD addr 5 len 2, no stalls
      clr_mon();
      send_cmd(1'b0, 16'd5, 16'd2, 1'b0);
      load_word(16'd5, 16'h1234, 1'b1);
      load_word(16'd6, 16'hABCD, 1'b1);
      wait_done("t1_done");
      chk("t1_busy_in_fin", {31'h0, BUSY}, 32'h1);
      cycle();
      chk("t1_busy_after", {30'h0, BUSY, DONE}, 32'h0);
      chk("t1_mw_pulses", mw_pulses, 2);
      chk("t1_mw_cycles", mw_cycles, 2);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_mem5", {16'h0, mem[5]}, 32'h1234);
      chk("t1_mem6", {16'h0, mem[6]}, 32'hABCD);
      chk("t1_wr_drained", exp_wr_q.size(), 0);

      // 2: DUMP addr 0 len 3 with TX_READY toggling 1-0-1
      clr_mon();
      exp_q.push_back(8'hC0); exp_q.push_back(8'h11);
      exp_q.push_back(8'hC1); exp_q.push_back(8'h22);
      exp_q.push_back(8'hC2); exp_q.push_back(8'h44);
      send_cmd(1'b1, 16'd0, 16'd3, 1'b0);
      for (int c = 0; c < 100 && !DONE; c++) begin
         TX_READY = (c % 2 == 0);
         cycle();
      end
      TX_READY = 1'b0;
      chk("t2_done", {31'h0, DONE}, 32'h1);
      cycle();
      chk("t2_tx_cnt", tx_cnt, 6);
      chk("t2_tx_drained", exp_q.size(), 0);
      chk("t2_no_mw", mw_cycles, 0);
      chk("t2_done_cnt", done_cnt, 1);

      // 3: out-of-range LOAD, then the largest legal one at the top
      clr_mon();
      RX_VALID = 1'b1;
      RX_DATA = 8'hEE;
      send_cmd(1'b0, 16'd198, 16'd3, 1'b0);
      chk("t3_err", {29'h0, ERR, BUSY, RX_READY}, 32'h6);
      cycle();
      chk("t3_err_end", {29'h0, ERR, BUSY, CMD_READY}, 32'h1);
      chk("t3_rx_idle", {31'h0, RX_READY}, 32'h0);
      RX_VALID = 1'b0;
      chk("t3_err_cnt", err_cnt, 1);
      chk("t3_no_mw", mw_cycles, 0);
      send_cmd(1'b0, 16'd198, 16'd2, 1'b0);
      load_word(16'd198, 16'h5AA5, 1'b1);
      load_word(16'd199, 16'h0FF0, 1'b1);
      wait_done("t3_done");
      cycle();
      chk("t3_mem198", {16'h0, mem[198]}, 32'h5AA5);
      chk("t3_mem199", {16'h0, mem[199]}, 32'h0FF0);
      chk("t3_err_cnt2", err_cnt, 1);

      // 4: zero-length commands, including ADDR+LEN == MEM_SIZE
      clr_mon();
      send_cmd(1'b0, 16'd10, 16'd0, 1'b0);
      chk("t4_load0_done", {30'h0, DONE, RX_READY}, 32'h2);
      cycle();
      send_cmd(1'b1, 16'd200, 16'd0, 1'b0);
      chk("t4_dump0_done", {29'h0, DONE, TX_VALID, ERR}, 32'h4);
      cycle();
      chk("t4_idle", {31'h0, BUSY}, 32'h0);
      chk("t4_counts", {mw_cycles[7:0], tx_cnt[7:0], err_cnt[7:0], done_cnt[7:0]}, 32'h00000002);

      // 5: reset during LD_WR of the second word of a 4-word LOAD
      clr_mon();
      send_cmd(1'b0, 16'd20, 16'd4, 1'b0);
      load_word(16'd20, 16'h1111, 1'b1);
      load_word(16'd21, 16'h2222, 1'b1);
      chk("t5_in_wr", {31'h0, MW_IO_ON}, 32'h1);
      RST = 1'b1;
      cycle();
      chk("t5_mw_off", {31'h0, MW_IO_ON}, 32'h0);
      chk("t5_idle", {24'h0, BUSY, DONE, ERR, 1'b0, DBG_STATE}, 32'h0);
      RST = 1'b0;
      repeat (3) cycle();
      chk("t5_no_done", done_cnt, 0);
      chk("t5_mem20", {16'h0, mem[20]}, 32'h1111);
      chk("t5_mem21", {16'h0, mem[21]}, 32'h2222);
      chk("t5_mem22", {16'h0, mem[22]}, 32'hF016);
      chk("t5_mem23", {16'h0, mem[23]}, 32'hF017);
      chk("t5_wr_drained", exp_wr_q.size(), 0);

      // 6: LOAD len 1 then DUMP same address, CMD_VALID held high
      clr_mon();
      send_cmd(1'b0, 16'd50, 16'd1, 1'b1);
      CMD_DUMP = 1'b1;
      load_word(16'd50, 16'h9C3E, 1'b1);
      wait_done("t6_load_done");
      cycle();
      chk("t6_idle_ready", {30'h0, CMD_READY, BUSY}, 32'h2);
      cycle();
      CMD_VALID = 1'b0;
      chk("t6_dump_started", {15'h0, BUSY, RADDR_IO}, {15'h0, 1'b1, 16'd50});
      exp_q.push_back(8'h9C);
      exp_q.push_back(8'h3E);
      TX_READY = 1'b1;
      wait_done("t6_dump_done");
      TX_READY = 1'b0;
      cycle();
      chk("t6_tx_drained", exp_q.size(), 0);
      chk("t6_tx_cnt", tx_cnt, 2);
      chk("t6_done_cnt", done_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_mem_port.md
Name: io_mem_port

Overview:
- IO-side initiator for the shared 16-bit instruction/data memory's IO port. It drives RADDR_IO, WADDR_IO, DATA_IN_IO and MW_IO_ON, and samples DATA_OUT_IO.
- Two command types: LOAD streams bytes from a host link into consecutive memory words (program download). DUMP reads consecutive words and streams them out as bytes (memory readback).
- Sits between the host byte link and the memory. The CPU port is untouched.

Parameters:
MEM_SIZE, 200, number of 16-bit words in the memory; legal addresses are 0..MEM_SIZE-1
ADDR_W, 16, width of address and length fields

Ports:
CLK  in  1  clock; all state updates on posedge. Memory commits IO writes on the following negedge.
RST  in  1  synchronous, active-high reset
CMD_VALID  in  1  command offered
CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY at posedge
CMD_DUMP  in  1  0 = LOAD, 1 = DUMP
CMD_ADDR  in  ADDR_W  first word address
CMD_LEN  in  ADDR_W  number of words
RX_VALID  in  1  host byte valid (LOAD data)
RX_READY  out  1  byte consumed when RX_VALID && RX_READY
RX_DATA  in  8  host byte
TX_VALID  out  1  output byte valid (DUMP data)
TX_READY  in  1  sink accepts when TX_VALID && TX_READY
TX_DATA  out  8  output byte
RADDR_IO  out  16  memory IO read address
DATA_OUT_IO  in  16  memory IO read data (combinational from RADDR_IO)
WADDR_IO  out  16  memory IO write address
DATA_IN_IO  out  16  memory IO write data
MW_IO_ON  out  1  memory IO write enable
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse: command completed
ERR  out  1  one-cycle pulse: command rejected for range

Behaviour:
- Reset
  - All outputs 0; state IDLE; address and count registers 0.
  - RST mid-command aborts on that edge. MW_IO_ON is 0 from the next cycle. Words already written remain in memory.
  - No DONE or ERR pulse on abort.
- State IDLE
  - CMD_READY=1; all other outputs 0.
  - On command accept, latch addr=CMD_ADDR and cnt=CMD_LEN.
  - Range check uses 17-bit CMD_ADDR+CMD_LEN.
    - Sum > MEM_SIZE: go to ERR state.
    - Else CMD_LEN==0: go to FIN.
    - Else go to LD_HI (LOAD) or DP_RD (DUMP).
- State ERR
  - ERR=1 for one cycle, then IDLE. No memory access is performed.
- LOAD path
  - LD_HI: RX_READY=1. On accept, hi=RX_DATA; go to LD_LO.
  - LD_LO: RX_READY=1. On accept, register WADDR_IO=addr, DATA_IN_IO={hi,RX_DATA}, MW_IO_ON=1; go to LD_WR.
  - LD_WR: RX_READY=0; MW_IO_ON held exactly this one cycle, so the memory commits at this cycle's negedge.
    - At the next posedge: MW_IO_ON=0, addr+=1, cnt-=1.
    - Go to FIN if cnt was 1, else LD_HI.
  - Byte order: high byte first.
  - Minimum 3 cycles per word. RX stalls (RX_VALID=0) hold the state indefinitely.
  - WADDR_IO and DATA_IN_IO hold their last values after the write; only MW_IO_ON returns to 0.
- DUMP path
  - RADDR_IO is registered and equals addr throughout the dump.
  - DP_RD: capture word=DATA_OUT_IO; go to DP_HI.
  - DP_HI: TX_VALID=1, TX_DATA=word[15:8]. On accept, go to DP_LO.
  - DP_LO: TX_VALID=1, TX_DATA=word[7:0]. On accept:
    - addr+=1 (RADDR_IO updates on the same edge), cnt-=1.
    - Go to FIN if cnt was 1, else DP_RD.
  - Once TX_VALID is raised, TX_VALID and TX_DATA stay stable until accepted.
  - MW_IO_ON is never asserted in DUMP.
  - Minimum 3 cycles per word.
- State FIN
  - DONE=1 for one cycle, BUSY=1; then IDLE.
  - A new command can be accepted on the first IDLE cycle.
- RX/TX outside their states
  - RX bytes offered outside LD_HI/LD_LO are not consumed (RX_READY=0).
  - TX_READY is ignored when TX_VALID=0.
- Boundaries
  - Last legal word MEM_SIZE-1 is accessible: ADDR+LEN==MEM_SIZE is legal.
  - CMD_LEN up to 65535 is allowed when in range. The count is ADDR_W wide and never wraps while in use.
- Concurrency: the CPU port may write the same address concurrently. Ordering at the memory is outside this block's scope.

Test Plan:
1. LOAD addr=5 len=2, bytes 12,34,AB,CD with no stalls → MW_IO_ON pulses twice, each one cycle wide. Memory[5]=1234 and memory[6]=ABCD. DONE pulses once; BUSY falls the same cycle DONE ends.
2. DUMP addr=0 len=3 after reset-time memory init, TX_READY toggling 1-0-1 → TX bytes appear in order C0,11,C1,22,C2,44. Each byte is held stable across stall cycles. MW_IO_ON stays 0 throughout.
3. LOAD addr=198 len=3 (MEM_SIZE=200) → ERR pulse one cycle, no MW_IO_ON, RX_READY stays 0. Then LOAD addr=198 len=2 → accepted; memory[198] and memory[199] written; DONE pulses.
4. CMD_LEN=0 in either mode → DONE one cycle after accept, no RX/TX/memory activity.
5. RST asserted in LD_WR of the second word of a 4-word LOAD → MW_IO_ON=0 next cycle, state IDLE, no DONE. The first word (and the second, if its negedge already passed) persists; the remaining words are unchanged.
6. Back-to-back commands: LOAD len=1 then DUMP of the same address with CMD_VALID held high → DUMP accepted on the first IDLE cycle after DONE and returns the freshly loaded word.
